perf_counter_bank: RTL and testbench
====================================

// Module: perf_counter_bank
// PURPOSE
//  Parametrised bank of NUM_CH event counters for pipeline statistics (total cycles, bubbles,
//  conditional/unconditional branches, ...), replacing the fixed four free-running counters.
//  Adds halt/go run-gating per channel, wrap or saturate mode, sticky overflow, per-channel
//  clear and a registered one-cycle read port. Sits beside the CPU top; fed by hazard/branch strobes.
// PARAMETERS
//  NUM_CH     4          number of counter channels (>=1)
//  CNT_W      32         counter width in bits (>=2)
//  SAT_MODE   0          0: wrap to 0 on overflow; 1: saturate at all-ones
//  GATE_MASK  {NUM_CH{1}} bit i=1: channel i counts only while run=go|~halt
//  SEL_W      $clog2(NUM_CH)+1  read-select width (derived; one spare bit flags out-of-range)
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              asynchronous, active-low reset
//  go         in   1              single-step/continue request
//  halt       in   1              CPU halted (syscall halt in WB)
//  inc        in   NUM_CH         per-channel event strobe, one count per cycle max
//  clr        in   1              synchronous clear of all counters and ovf flags
//  clr_ch     in   NUM_CH         synchronous clear of selected channels
//  rd_req     in   1              read request
//  rd_sel     in   SEL_W          channel index to read
//  rd_shadow  in   1              read snapshot copy instead of live (see CONFIGURATION)
//  snap       in   1              capture all counters into shadow (see CONFIGURATION)
//  rd_valid   out  1              read data valid, exactly one cycle after rd_req
//  rd_data    out  CNT_W          read value
//  rd_ovf     out  1              sticky overflow flag of the read channel
//  rd_err     out  1              rd_sel >= NUM_CH
//  cnt_flat   out  NUM_CH*CNT_W   live counters, channel i at [i*CNT_W +: CNT_W]
//  ovf        out  NUM_CH         live sticky overflow flags
// BEHAVIOUR
//  - Reset (rst=0, async): all counters, ovf, shadow, rd_valid, rd_data, rd_ovf, rd_err = 0.
//  - run = go | ~halt. en[i] = inc[i] & (GATE_MASK[i] ? run : 1).
//  - Per channel, priority: clr|clr_ch[i] -> cnt=0, ovf=0 (clear beats increment; result 0 not 1);
//    else en[i] & cnt!=max -> cnt+1; else en[i] & cnt==max -> ovf=1 and cnt=0 (SAT_MODE=0)
//    or cnt stays max (SAT_MODE=1); else hold.
//  - ovf sticky; cleared only by clr, clr_ch[i] or reset. Flat outputs are the registers (0 latency).
//  - Read: rd_req in cycle N -> cycle N+1 rd_valid=1, rd_data/rd_ovf = channel value as registered
//    at start of cycle N (pre-update). Back-to-back rd_req every cycle is legal; no stall.
//  - rd_sel >= NUM_CH: rd_data=0, rd_ovf=0, rd_err=1. rd_req=0: rd_valid=0, rd_data/rd_ovf/rd_err hold.
//  - No state machine beyond counters; all state registered on clk, no combinational rd path.
// CONFIGURATION
//  - Macro PERF_SNAPSHOT_EN defined: NUM_CH shadow registers; snap in cycle N copies pre-update
//    counter values (snap with clr captures pre-clear values); shadow unaffected by clr/clr_ch;
//    rd_shadow=1 returns shadow value, rd_ovf still live flag.
//  - Undefined: no shadow storage; snap ignored; rd_shadow ignored, reads always live. Ports unchanged.
// STRUCTURE
//  - Package perf_pkg: channel index constants CH_TOTAL=0, CH_BUBBLE=1, CH_COND_BR=2,
//    CH_UNCOND_BR=3; SAT_MODE encodings MODE_WRAP=0, MODE_SAT=1.
//  - Sub-module perf_counter_cell (counter + sticky ovf, params CNT_W, SAT_MODE), generated NUM_CH times;
//    top holds gating, read register and optional shadow bank.
// TESTING
//  1 Reset: drive inc all-ones 5 cycles, assert rst=0 mid-cycle -> cnt_flat, ovf, rd_* = 0 immediately.
//  2 Gating: GATE_MASK=4'b0011, halt=1, go=0, inc=4'b1111 x3 -> ch0,ch1=0, ch2,ch3=3; pulse go 1 cycle -> ch0,ch1=1.
//  3 Overflow: CNT_W=4; 17 increments ch0 -> SAT_MODE=0: cnt=1, ovf[0]=1; SAT_MODE=1: cnt=15, ovf[0]=1.
//  4 Clear priority: ch1=7, clr_ch=4'b0010 with inc[1]=1 same cycle -> ch1=0, ovf[1]=0; others unchanged.
//  5 Read: ch2=9, rd_req rd_sel=2 with inc[2]=1 -> next cycle rd_valid=1, rd_data=9, ch2=10;
//    rd_sel=5 (NUM_CH=4) -> rd_err=1, rd_data=0.
//  6 PERF_SNAPSHOT_EN: ch0=20, snap+clr same cycle -> ch0=0; rd_shadow=1 rd_sel=0 -> rd_data=20;
//    macro undefined -> rd_data=0.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants for the performance counter bank: channel roles and overflow-mode encodings.
package perf_pkg;

  // Conventional channel assignment for the pipeline statistics counters
  localparam int unsigned CH_TOTAL     = 0;
  localparam int unsigned CH_BUBBLE    = 1;
  localparam int unsigned CH_COND_BR   = 2;
  localparam int unsigned CH_UNCOND_BR = 3;

  // Behaviour of a counter when it is incremented at all-ones
  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

endpackage

// File: rtl/perf_counter_cell.sv
// Single event counter with a sticky overflow flag; clear wins over increment.
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned SAT_MODE = MODE_WRAP
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             at_max;

  assign at_max = &cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clr_i) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (en_i) begin
      if (!at_max) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
        cnt_d = (SAT_MODE == MODE_SAT) ? cnt_q : '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of run-gated event counters with a registered read port.
// Optional snapshot shadow bank enabled by defining PERF_SNAPSHOT_EN.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned        NUM_CH    = 4,
  parameter int unsigned        CNT_W     = 32,
  parameter int unsigned        SAT_MODE  = MODE_WRAP,
  parameter logic [NUM_CH-1:0]  GATE_MASK = {NUM_CH{1'b1}},
  parameter int unsigned        SEL_W     = $clog2(NUM_CH) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    go_i,
  input  logic                    halt_i,
  input  logic [NUM_CH-1:0]       inc_i,
  input  logic                    clr_i,
  input  logic [NUM_CH-1:0]       clr_ch_i,
  input  logic                    rd_req_i,
  input  logic [SEL_W-1:0]        rd_sel_i,
  input  logic                    rd_shadow_i,
  input  logic                    snap_i,
  output logic                    rd_valid_o,
  output logic [CNT_W-1:0]        rd_data_o,
  output logic                    rd_ovf_o,
  output logic                    rd_err_o,
  output logic [NUM_CH*CNT_W-1:0] cnt_flat_o,
  output logic [NUM_CH-1:0]       ovf_o
);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("perf_counter_bank: NUM_CH must be at least 1");
  end
  if (CNT_W < 2) begin : g_bad_cnt_w
    $error("perf_counter_bank: CNT_W must be at least 2");
  end

  logic                    run;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH*CNT_W-1:0] cnt_flat;
  logic [NUM_CH-1:0]       ovf;

  // Halted CPU freezes gated channels unless a go request steps it
  assign run = go_i | ~halt_i;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign en[i] = inc_i[i] & (GATE_MASK[i] ? run : 1'b1);

    perf_counter_cell #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .clr_i  (clr_i | clr_ch_i[i]),
      .en_i   (en[i]),
      .cnt_o  (cnt_flat[i*CNT_W +: CNT_W]),
      .ovf_o  (ovf[i])
    );
  end

  // Read source: live counters, or the shadow bank when snapshots are built in
  logic [NUM_CH*CNT_W-1:0] rd_src;

`ifdef PERF_SNAPSHOT_EN
  logic [NUM_CH*CNT_W-1:0] shadow_q, shadow_d;

  assign shadow_d = snap_i ? cnt_flat : shadow_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign rd_src = rd_shadow_i ? shadow_q : cnt_flat;
`else
  logic unused_snap;

  assign unused_snap = snap_i ^ rd_shadow_i;
  assign rd_src      = cnt_flat;
`endif

  logic             rd_in_range;
  logic [CNT_W-1:0] sel_data;
  logic             sel_ovf;

  assign rd_in_range = 32'(rd_sel_i) < NUM_CH;

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (32'(rd_sel_i) == i) begin
        sel_data = rd_src[i*CNT_W +: CNT_W];
        sel_ovf  = ovf[i];
      end
    end
  end

  logic             rd_valid_q, rd_valid_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic             rd_ovf_q, rd_ovf_d;
  logic             rd_err_q, rd_err_d;

  always_comb begin
    rd_valid_d = rd_req_i;
    rd_data_d  = rd_data_q;
    rd_ovf_d   = rd_ovf_q;
    rd_err_d   = rd_err_q;
    if (rd_req_i) begin
      rd_data_d = rd_in_range ? sel_data : '0;
      rd_ovf_d  = rd_in_range ? sel_ovf : 1'b0;
      rd_err_d  = ~rd_in_range;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_ovf_q   <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_ovf_q   <= rd_ovf_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;
  assign rd_ovf_o   = rd_ovf_q;
  assign rd_err_o   = rd_err_q;
  assign cnt_flat_o = cnt_flat;
  assign ovf_o      = ovf;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench: one 8-bit gated bank plus two 4-bit banks (wrap, saturate).
module tb_perf_counter_bank;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       go_i = 1'b0;
  logic       halt_i = 1'b0;
  logic [3:0] inc_i = '0;
  logic       clr_i = 1'b0;
  logic [3:0] clr_ch_i = '0;
  logic       rd_req_i = 1'b0;
  logic [2:0] rd_sel_i = '0;
  logic       rd_shadow_i = 1'b0;
  logic       snap_i = 1'b0;

  logic        a_rd_valid, a_rd_ovf, a_rd_err;
  logic [7:0]  a_rd_data;
  logic [31:0] a_cnt;
  logic [3:0]  a_ovf;

  logic        b_rd_valid, b_rd_ovf, b_rd_err;
  logic [3:0]  b_rd_data;
  logic [15:0] b_cnt;
  logic [3:0]  b_ovf;

  logic        c_rd_valid, c_rd_ovf, c_rd_err;
  logic [3:0]  c_rd_data;
  logic [15:0] c_cnt;
  logic [3:0]  c_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  perf_counter_bank #(
    .NUM_CH (4), .CNT_W (8), .SAT_MODE (0), .GATE_MASK (4'b0011)
  ) dut_a (
    .clk_i (clk_i), .rst_ni (rst_ni), .go_i (go_i), .halt_i (halt_i), .inc_i (inc_i),
    .clr_i (clr_i), .clr_ch_i (clr_ch_i), .rd_req_i (rd_req_i), .rd_sel_i (rd_sel_i),
    .rd_shadow_i (rd_shadow_i), .snap_i (snap_i), .rd_valid_o (a_rd_valid),
    .rd_data_o (a_rd_data), .rd_ovf_o (a_rd_ovf), .rd_err_o (a_rd_err),
    .cnt_flat_o (a_cnt), .ovf_o (a_ovf)
  );

  perf_counter_bank #(
    .NUM_CH (4), .CNT_W (4), .SAT_MODE (0)
  ) dut_b (
    .clk_i (clk_i), .rst_ni (rst_ni), .go_i (go_i), .halt_i (halt_i), .inc_i (inc_i),
    .clr_i (clr_i), .clr_ch_i (clr_ch_i), .rd_req_i (rd_req_i), .rd_sel_i (rd_sel_i),
    .rd_shadow_i (rd_shadow_i), .snap_i (snap_i), .rd_valid_o (b_rd_valid),
    .rd_data_o (b_rd_data), .rd_ovf_o (b_rd_ovf), .rd_err_o (b_rd_err),
    .cnt_flat_o (b_cnt), .ovf_o (b_ovf)
  );

  perf_counter_bank #(
    .NUM_CH (4), .CNT_W (4), .SAT_MODE (1)
  ) dut_c (
    .clk_i (clk_i), .rst_ni (rst_ni), .go_i (go_i), .halt_i (halt_i), .inc_i (inc_i),
    .clr_i (clr_i), .clr_ch_i (clr_ch_i), .rd_req_i (rd_req_i), .rd_sel_i (rd_sel_i),
    .rd_shadow_i (rd_shadow_i), .snap_i (snap_i), .rd_valid_o (c_rd_valid),
    .rd_data_o (c_rd_data), .rd_ovf_o (c_rd_ovf), .rd_err_o (c_rd_err),
    .cnt_flat_o (c_cnt), .ovf_o (c_ovf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle just after it
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    #12 rst_ni = 1'b1;
    check("reset_cnt", 64'(a_cnt), 64'h0);
    check("reset_ovf", 64'(a_ovf), 64'h0);
    check("reset_rd_valid", 64'(a_rd_valid), 64'h0);

    // Async reset mid-cycle while counting and reading
    inc_i = 4'hF; rd_req_i = 1'b1; rd_sel_i = 3'd0;
    tick(5);
    check("pre_reset_cnt", 64'(a_cnt), 64'h05050505);
    check("pre_reset_rd_data", 64'(a_rd_data), 64'd4);
    #3 rst_ni = 1'b0;
    #1;
    check("async_reset_cnt", 64'(a_cnt), 64'h0);
    check("async_reset_rd_valid", 64'(a_rd_valid), 64'h0);
    check("async_reset_rd_data", 64'(a_rd_data), 64'h0);
    inc_i = '0; rd_req_i = 1'b0;
    #2 rst_ni = 1'b1;

    // Halt gating on channels 0 and 1 only
    tick(1);
    halt_i = 1'b1; go_i = 1'b0; inc_i = 4'hF;
    tick(3);
    check("gate_halted", 64'(a_cnt), 64'h03030000);
    go_i = 1'b1;
    tick(1);
    check("gate_go_pulse", 64'(a_cnt), 64'h04040101);
    go_i = 1'b0; halt_i = 1'b0; inc_i = '0;

    // Per-channel clear beats a same-cycle increment
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    inc_i = 4'b1110; tick(7);
    check("clr_setup", 64'(a_cnt), 64'h07070700);
    clr_ch_i = 4'b0010; tick(1);
    check("clr_ch_priority", 64'(a_cnt), 64'h08080000);
    check("clr_ch_ovf", 64'(a_ovf), 64'h0);
    clr_ch_i = '0; inc_i = '0;

    // Registered read returns pre-update value
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    inc_i = 4'b0100; tick(9);
    rd_req_i = 1'b1; rd_sel_i = 3'd2; tick(1);
    check("rd_valid", 64'(a_rd_valid), 64'h1);
    check("rd_data_pre_update", 64'(a_rd_data), 64'd9);
    check("rd_err_in_range", 64'(a_rd_err), 64'h0);
    check("rd_live_after", 64'(a_cnt[23:16]), 64'd10);
    inc_i = '0; rd_sel_i = 3'd5; tick(1);
    check("rd_err_oob", 64'(a_rd_err), 64'h1);
    check("rd_data_oob", 64'(a_rd_data), 64'h0);
    rd_req_i = 1'b0; tick(1);
    check("rd_idle_valid", 64'(a_rd_valid), 64'h0);
    check("rd_idle_err_hold", 64'(a_rd_err), 64'h1);
    rd_req_i = 1'b1; rd_sel_i = 3'd2; tick(1);
    check("rd_b2b_first", 64'(a_rd_data), 64'd10);
    rd_sel_i = 3'd3; tick(1);
    check("rd_b2b_second", 64'(a_rd_data), 64'd0);
    check("rd_b2b_valid", 64'(a_rd_valid), 64'h1);
    rd_req_i = 1'b0;

    // Overflow in 4-bit wrap and saturate banks
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    inc_i = 4'b0001; tick(17); inc_i = '0;
    check("wrap_cnt", 64'(b_cnt[3:0]), 64'd1);
    check("wrap_ovf", 64'(b_ovf), 64'b0001);
    check("sat_cnt", 64'(c_cnt[3:0]), 64'd15);
    check("sat_ovf", 64'(c_ovf), 64'b0001);
    check("wide_no_ovf", 64'(a_cnt[7:0]), 64'd17);
    rd_req_i = 1'b1; rd_sel_i = 3'd0; tick(1); rd_req_i = 1'b0;
    check("rd_ovf_sticky", 64'(b_rd_ovf), 64'h1);
    check("rd_data_wrap", 64'(b_rd_data), 64'd1);
    clr_ch_i = 4'b0001; tick(1); clr_ch_i = '0;
    check("ovf_clr_ch", 64'(b_ovf), 64'h0);

    // Snapshot captures pre-clear value
    clr_i = 1'b1; tick(1); clr_i = 1'b0;
    inc_i = 4'b0001; tick(20);
    snap_i = 1'b1; clr_i = 1'b1; tick(1);
    snap_i = 1'b0; clr_i = 1'b0; inc_i = '0;
    check("snap_clr_live", 64'(a_cnt[7:0]), 64'd0);
    rd_req_i = 1'b1; rd_shadow_i = 1'b1; rd_sel_i = 3'd0; tick(1);
    rd_req_i = 1'b0; rd_shadow_i = 1'b0;
`ifdef PERF_SNAPSHOT_EN
    check("snap_read", 64'(a_rd_data), 64'd20);
`else
    check("snap_read", 64'(a_rd_data), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
